// File: rtl/slice_select_pipe.sv
// slice_select_pipe
//   Registered slice selector. Picks one SLICE_W-bit slice out of a packed
//   NUM_SLICES-slice word, either from an explicit select code (direct mode)
//   or from an internal wrapping slice counter (scan mode). Valid/ready on
//   both sides with a single output register stage (latency 1).
//
// Ports
//   clk, rst_n    clock (rising edge), synchronous active-low reset
//   mode          0 = direct (in_sel), 1 = scan (internal counter)
//   scan_clr      force scan counter to 0 for this cycle
//   in_valid/in_ready/in_sel/in_data      input beat
//   out_valid/out_ready                   output handshake
//   out_data      selected slice (0 when out_zero)
//   out_idx       slice index used (0 when out_zero)
//   out_zero      direct select code was out of range
//   out_last      scan beat used the final slice index
module slice_select_pipe #(
  parameter  int SLICE_W    = 3,
  parameter  int NUM_SLICES = 7,
  parameter  int SEL_W      = 5,
  parameter  int SEL_LIMIT  = 28,
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic                          scan_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic [NUM_SLICES*SLICE_W-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W-1:0]            out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_zero,
  output logic                          out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // output stage
  logic               r_valid;
  logic [SLICE_W-1:0] r_data;
  logic [IDX_W-1:0]   r_idx;
  logic               r_zero;
  logic               r_last;

  // scan counter
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_cnt_eff;

  logic                                w_accept;
  logic                                w_in_range;
  logic [SEL_W-1:0]                    w_sel_mod;
  logic [IDX_W-1:0]                    w_idx;
  logic                                w_zero;
  logic                                w_last;
  logic [SLICE_W-1:0]                  w_slice;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]  w_slices;

  // Unpack the source word into addressable slices.
  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    assign w_slices[k] = in_data[k*SLICE_W +: SLICE_W];
  end

  assign in_ready   = !r_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_in_range = 32'(in_sel) < 32'(SEL_LIMIT);
  assign w_sel_mod  = in_sel % SEL_W'(NUM_SLICES);
  // scan_clr overrides the counter for the current beat, not just the next one.
  assign w_cnt_eff  = scan_clr ? '0 : r_cnt;

  // Index / flag selection for the beat currently on the input.
  always_comb begin
    w_idx  = '0;
    w_zero = 1'b0;
    w_last = 1'b0;
    if (mode) begin
      w_idx  = w_cnt_eff;
      w_last = (w_cnt_eff == LAST_IDX);
    end else if (w_in_range) begin
      w_idx  = IDX_W'(w_sel_mod);
    end else begin
      w_zero = 1'b1;
    end
  end

  // Slice mux; indices beyond NUM_SLICES-1 never occur but fall back to 0.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < NUM_SLICES; k++)
      if (w_idx == IDX_W'(k)) w_slice = w_slices[k];
  end

  // Counter next state: advance from the effective value on scan accepts,
  // so a scan_clr with an accept lands on 1 rather than 0.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept && mode)
      w_cnt_nxt = (w_cnt_eff == LAST_IDX) ? '0 : w_cnt_eff + 1'b1;
    else if (scan_clr)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_zero  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_zero ? '0 : w_slice;
        r_idx   <= w_idx;
        r_zero  <= w_zero;
        r_last  <= w_last;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_zero  = r_zero;
  assign out_last  = r_last;

endmodule

// File: tb/tb_slice_select_pipe.sv
// Scoreboard bench for slice_select_pipe: the driver pushes expected beats
// on accept, a negedge monitor pops and compares on each output handshake.
module tb_slice_select_pipe;

  localparam logic [20:0] D0 = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  // slice k: 0->3 1->4 2->0 3->5 4->2 5->7 6->1
  localparam logic [20:0] D1 = {3'd1, 3'd7, 3'd2, 3'd5, 3'd0, 3'd4, 3'd3};

  typedef struct {
    logic [2:0] data;
    logic [2:0] idx;
    logic       zero;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, mode, scan_clr, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_sel;
  logic [20:0] in_data;
  logic [2:0]  out_data, out_idx;
  logic        out_zero, out_last;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  slice_select_pipe dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .scan_clr(scan_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_zero(out_zero), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed output handshake with the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("beat_data", 32'(out_data), 32'(e.data));
        chk("beat_idx",  32'(out_idx),  32'(e.idx));
        chk("beat_zero", 32'(out_zero), 32'(e.zero));
        chk("beat_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  // Issue one beat (called #1 after a posedge); returns #1 after the accepting edge.
  task automatic beat(input logic m, input logic clr, input logic [4:0] sel,
                      input int eidx, input logic ez, input logic el);
    exp_t e;
    bit   acc = 1'b0;
    mode = m; scan_clr = clr; in_sel = sel; in_valid = 1'b1;
    e.data = ez ? 3'd0 : in_data[eidx*3 +: 3];
    e.idx  = 3'(eidx);
    e.zero = ez;
    e.last = el;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) q.push_back(e);
    else chk("accept_timeout", 32'(0), 32'(1));
    #1;
    in_valid = 1'b0;
    scan_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; scan_clr = 1'b0; in_valid = 1'b0;
    in_sel = '0; in_data = D0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data",  32'(out_data),  32'(0));
    chk("rst_idx",   32'(out_idx),   32'(0));
    chk("rst_zero",  32'(out_zero),  32'(0));
    chk("rst_last",  32'(out_last),  32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // direct mode, in range and out of range
    beat(0, 0, 5'd10, 3, 0, 0);
    beat(0, 0, 5'd27, 6, 0, 0);
    in_data = D1;
    beat(0, 0, 5'd10, 3, 0, 0);
    beat(0, 0, 5'd0,  0, 0, 0);
    beat(0, 0, 5'd13, 6, 0, 0);
    beat(0, 0, 5'd28, 0, 1, 0);
    beat(0, 0, 5'd31, 0, 1, 0);
    in_data = D0;

    // scan: 8 back-to-back beats, wrap after index 6
    for (int k = 0; k < 8; k++)
      beat(1, 0, 5'd31, k % 7, 0, (k == 6));
    idle(2);

    // backpressure
    out_ready = 1'b0;
    beat(0, 0, 5'd1, 1, 0, 0);
    mode = 1'b0; in_sel = 5'd2; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready),  32'(0));
      chk("bp_valid",    32'(out_valid), 32'(1));
      chk("bp_data",     32'(out_data),  32'(1));
      chk("bp_idx",      32'(out_idx),   32'(1));
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    beat(0, 0, 5'd2, 2, 0, 0);
    @(negedge clk);
    chk("nobubble_valid", 32'(out_valid), 32'(1));
    chk("nobubble_data",  32'(out_data),  32'(2));
    @(posedge clk); #1;

    // scan_clr: counter is 1 after the wrap; advance to 4
    in_data = D1;
    beat(1, 0, 5'd0, 1, 0, 0);
    beat(1, 0, 5'd0, 2, 0, 0);
    beat(1, 0, 5'd0, 3, 0, 0);
    beat(1, 1, 5'd0, 0, 0, 0);
    beat(1, 0, 5'd0, 1, 0, 0);
    beat(0, 0, 5'd2, 2, 0, 0);
    beat(1, 0, 5'd0, 2, 0, 0);
    idle(2);

    // reset while a beat is held under backpressure (counter is 3)
    out_ready = 1'b0;
    beat(1, 0, 5'd0, 3, 0, 0);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_idx",   32'(out_idx),   32'(0));
    chk("midrst_data",  32'(out_data),  32'(0));
    chk("midrst_ready", 32'(in_ready),  32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(1, 0, 5'd0, 0, 0, 0);
    beat(1, 0, 5'd0, 1, 0, 0);

    for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
    idle(2);
    chk("drain", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
